tri_bus_arbiter: RTL
====================

# tri_bus_arbiter

Round-robin arbiter for the shared tri-state data bus. It accepts requests from up to N_MASTERS bus drivers and grants ownership to exactly one at a time. It produces the registered one-hot enables that drive the per-master `En` inputs of the tri-state buffer stage directly downstream. It enforces a dead turnaround window between owners so that two buffers never drive the bus in the same cycle.

## Interface
- N_MASTERS, 4: number of requesters/tri-state drivers (2..16).
- TURN_CYC, 1: idle cycles between owners (>=1).
- MAX_HOLD, 16: max consecutive grant cycles under lock (used only with timeout feature).
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset.
- Req  in  N_MASTERS  per-master bus request, level-sensitive.
- Lock  in  N_MASTERS  per-master burst lock; meaningful only for current owner.
- Grant  out  N_MASTERS  one-hot (or zero) ownership handshake to masters.
- DrvEn  out  N_MASTERS  one-hot (or zero) tri-state enables; wired to the buffers' `En`.
- Owner  out  $clog2(N_MASTERS)  index of current owner; 0 when no grant.
- BusIdle  out  1  high when no master drives the bus.

## Operation
- FSM states: IDLE, OWN, TURN.
- IDLE: Grant=DrvEn=0, BusIdle=1. Any Req bit set -> OWN, granting the round-robin winner.
- Round-robin: search starts at last_owner+1, wraps modulo N_MASTERS. last_owner resets to N_MASTERS-1, so master 0 has first priority after reset.
- OWN: Grant[owner]=DrvEn[owner]=1, BusIdle=0. Ownership is kept while Req[owner]=1 and either Lock[owner]=1 or no other Req bit is set.
- OWN -> TURN when Req[owner] drops, or when Lock[owner]=0 and another master requests. last_owner<=owner.
- TURN: all enables 0, BusIdle=1 for exactly TURN_CYC cycles. Then -> OWN with the next winner if any Req is set, else -> IDLE.
- Req sampled at the last TURN cycle determines the winner. Requests arriving during TURN are eligible.
- Grant and DrvEn are identical registered outputs. The invariant popcount(DrvEn)<=1 holds in every cycle.
- A master dropping Req while not owner has no effect; Lock from non-owners is ignored.
- Reset asserted mid-burst: all outputs go to 0 immediately (asynchronously), BusIdle=1, state IDLE, last_owner=N_MASTERS-1.

## Timing
- Req rise in IDLE at edge k -> Grant/DrvEn high after edge k+1 (1-cycle latency).
- Owner Req falls at edge k -> DrvEn low after edge k+1. Next owner's DrvEn high after edge k+1+TURN_CYC.
- Handover latency between masters = 1 + TURN_CYC cycles.
- No combinational path from Req/Lock to any output.
- Reset values: Grant=0, DrvEn=0, Owner=0, BusIdle=1.

## Configuration
- ARB_TIMEOUT_EN defined: a hold counter of width $clog2(MAX_HOLD+1) counts OWN cycles and clears on entering OWN. When it reaches MAX_HOLD and another master requests, the FSM forces OWN -> TURN regardless of Lock. With no competing requester, the counter saturates and ownership continues.
- ARB_TIMEOUT_EN undefined: no counter; a locked owner holds the bus indefinitely; MAX_HOLD is unused.

## Structure
- Shared package tri_bus_pkg: state enum (IDLE, OWN, TURN), default N_MASTERS/TURN_CYC constants, and the function computing the owner index width.
- One sub-module: rr_pick, a combinational round-robin selector (inputs Req, last_owner; outputs valid, winner index).
- The turnaround counter and the hold counter live in the top module.

## Test plan
- Reset, then Req=4'b0001 -> Grant=DrvEn=0001 one cycle later, Owner=0, BusIdle=0.
- Req=4'b1111 with no Lock, each master drops Req after 2 owned cycles -> grant order 0,1,2,3, with one TURN cycle (all-zero DrvEn) between owners.
- Owner 1 holds Lock=1 for 30 cycles while Req[2]=1, macro undefined -> owner stays 1 for all 30 cycles; master 2 is granted 2 cycles after Lock and Req[1] drop.
- Same stimulus with ARB_TIMEOUT_EN, MAX_HOLD=16 -> DrvEn[1] drops after 16 owned cycles, DrvEn[2] rises after the turnaround.
- TURN_CYC=3, owner 0 releases with Req[3] pending -> exactly 3 cycles with DrvEn=0, then DrvEn=1000.
- Rst_n pulled low during a locked burst by owner 2 -> outputs zero without waiting for a clock; after release, Req=1111 -> master 0 is granted first.
- Throughout all scenarios, the bench asserts popcount(DrvEn)<=1 every cycle and DrvEn==Grant.

Source files
------------

// File: rtl/tri_bus_pkg.sv
// Shared types and constants for the tri-state bus arbiter: FSM state encoding,
// default sizing and the owner-index width helper.
package tri_bus_pkg;

    localparam int N_MASTERS_DEF = 4;
    localparam int TURN_CYC_DEF  = 1;
    localparam int MAX_HOLD_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_e;

    // At least one bit so a 1-master index still has a legal vector width.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester strictly after last_owner,
// wrapping modulo N.
module rr_pick
    import tri_bus_pkg::*;
#(
    parameter int N = N_MASTERS_DEF,
    parameter int W = owner_w(N_MASTERS_DEF)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_owner,
    output logic         valid,
    output logic [W-1:0] winner
);

    always_comb begin
        logic         found;
        logic [W-1:0] cand;
        int           idx;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        idx    = 0;
        for (int i = 1; i <= N; i++) begin
            idx  = (int'(last_owner) + i) % N;
            cand = W'(idx);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus with a dead turnaround window.
// Optional ARB_TIMEOUT_EN: a locked owner is forced off after MAX_HOLD cycles when contended.
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEF,
    parameter int TURN_CYC  = TURN_CYC_DEF,
    parameter int MAX_HOLD  = MAX_HOLD_DEF
) (
    input  logic                           Clk,
    input  logic                           Rst_n,
    input  logic [N_MASTERS-1:0]           Req,
    input  logic [N_MASTERS-1:0]           Lock,
    output logic [N_MASTERS-1:0]           Grant,
    output logic [N_MASTERS-1:0]           DrvEn,
    output logic [owner_w(N_MASTERS)-1:0]  Owner,
    output logic                           BusIdle
);

    localparam int OW = owner_w(N_MASTERS);
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    if (N_MASTERS < 2 || TURN_CYC < 1 || MAX_HOLD < 1) begin : g_param_range_invalid
    end

    arb_state_e           state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        last_owner_q, last_owner_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic                 idle_q, idle_d;
    logic [TW-1:0]        turn_cnt_q, turn_cnt_d;

    logic                 pick_valid;
    logic [OW-1:0]        pick_idx;
    logic [N_MASTERS-1:0] pick_onehot;
    logic                 req_own, lock_own, others_req, keep_own;
    logic                 hold_expired;

    rr_pick #(
        .N (N_MASTERS),
        .W (OW)
    ) u_rr_pick (
        .req        (Req),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .winner     (pick_idx)
    );

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_onehot
        assign pick_onehot[gi] = (pick_idx == OW'(gi));
    end

    // grant_q is one-hot on the owner while in OWN, so it doubles as the owner mask.
    assign req_own    = |(Req & grant_q);
    assign lock_own   = |(Lock & grant_q);
    assign others_req = |(Req & ~grant_q);

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;

    assign hold_inc     = (hold_cnt_q == HW'(MAX_HOLD)) ? hold_cnt_q : hold_cnt_q + HW'(1);
    assign hold_expired = (hold_inc == HW'(MAX_HOLD)) && others_req;
    assign hold_cnt_d   = (state_q == OWN) ? hold_inc : '0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    assign keep_own = req_own && (lock_own || !others_req) && !hold_expired;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        idle_d       = idle_q;
        turn_cnt_d   = turn_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                    idle_d  = 1'b0;
                end
            end
            OWN: begin
                if (!keep_own) begin
                    state_d      = TURN;
                    last_owner_d = owner_q;
                    owner_d      = '0;
                    grant_d      = '0;
                    idle_d       = 1'b1;
                    turn_cnt_d   = '0;
                end
            end
            TURN: begin
                // Requests sampled in the final dead cycle pick the next owner.
                if (turn_cnt_q == TW'(TURN_CYC - 1)) begin
                    if (pick_valid) begin
                        state_d = OWN;
                        owner_d = pick_idx;
                        grant_d = pick_onehot;
                        idle_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                grant_d = '0;
                idle_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(N_MASTERS - 1);
            grant_q      <= '0;
            idle_q       <= 1'b1;
            turn_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            idle_q       <= idle_d;
            turn_cnt_q   <= turn_cnt_d;
        end
    end

    assign Grant   = grant_q;
    assign DrvEn   = grant_q;
    assign Owner   = owner_q;
    assign BusIdle = idle_q;

endmodule
